// File: rtl/onehot_decoder_seq.sv
// Registered binary-to-one-hot decoder with a valid/ready DECODE mode and a
// free-running SCAN mode that walks the active output at a programmable rate.
module onehot_decoder_seq #(
  parameter int SEL_W      = 3,
  parameter int SCAN_DIV   = 4,
  parameter bit ACTIVE_LOW = 0,
  localparam int OUT_W     = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             out_valid,
  output logic             wrap,
  output logic [1:0]       dbg_state
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [OUT_W-1:0] INACTIVE = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
  localparam logic [SEL_W-1:0] IDX_LAST = {SEL_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic             wrap_q, wrap_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [OUT_W-1:0] oh_sel, oh_next;
  logic             accept;
  logic [SEL_W-1:0] idx_inc;

  // Handshake: a sel transfer happens on a rising edge where in_valid and
  // in_ready are both high; in_ready depends only on current en/mode/rst.
  assign in_ready = en & ~mode & ~rst;
  assign accept   = in_valid & in_ready;
  assign idx_inc  = idx_q + SEL_W'(1);

  always_comb begin
    oh_sel          = '0;
    oh_sel[sel]     = 1'b1;
    oh_next         = '0;
    oh_next[idx_inc] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    wrap_d      = 1'b0;
    div_d       = div_q;

    if (!en) begin
      state_d     = IDLE;
      out_d       = INACTIVE;
      out_valid_d = 1'b0;
      div_d       = '0;
    end else if (accept) begin
      // Covers the SCAN-to-DECODE cycle too: the decode result wins.
      state_d     = HOLD;
      out_d       = oh_sel ^ INACTIVE;
      idx_d       = sel;
      out_valid_d = 1'b1;
      div_d       = '0;
    end else if (mode) begin
      if (state_q != SCAN) begin
        state_d     = SCAN;
        idx_d       = '0;
        out_d       = {{(OUT_W-1){1'b0}}, 1'b1} ^ INACTIVE;
        out_valid_d = 1'b1;
        div_d       = '0;
      end else if (div_q == DIV_LAST) begin
        div_d  = '0;
        idx_d  = idx_inc;
        out_d  = oh_next ^ INACTIVE;
        wrap_d = (idx_q == IDX_LAST);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end else if (state_q == SCAN) begin
      state_d     = IDLE;
      out_d       = INACTIVE;
      out_valid_d = 1'b0;
      div_d       = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_q       <= INACTIVE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      div_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
      div_q       <= div_d;
    end
  end

  assign out       = out_q;
  assign idx       = idx_q;
  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;
  assign dbg_state = state_q;

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
- Registered, parametrised binary-to-one-hot decoder for select and strobe generation, e.g. display digit select or bank enables.
- DECODE mode: accepts a binary index through a valid/ready handshake and holds the matching one-hot output until the next index is accepted.
- SCAN mode: walks the active output through all positions at a programmable rate and flags each wrap.
- Sits between control FSMs and per-channel enable/select lines.

Parameters:
SEL_W, 3, width of binary index; number of outputs OUT_W = 2**SEL_W (derived, not overridable)
SCAN_DIV, 4, clock cycles each position stays active in SCAN mode; legal range 1..65535
ACTIVE_LOW, 0, 1 = outputs asserted low (inactive value all-ones); 0 = asserted high

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  block enable; low forces outputs inactive
mode  input  1  0 = DECODE, 1 = SCAN
in_valid  input  1  sel is valid this cycle
in_ready  output  1  block accepts sel this cycle (combinational)
sel  input  SEL_W  binary index to decode
out  output  OUT_W  one-hot (or one-cold if ACTIVE_LOW) registered decode
idx  output  SEL_W  binary index currently driven on out
out_valid  output  1  out holds a decoded position
wrap  output  1  one-cycle pulse when SCAN moves from position OUT_W-1 to position 0

Behaviour:
- Reset (async assert, sync release): out = inactive (all-0, or all-1 if ACTIVE_LOW); idx = 0; out_valid = 0; wrap = 0; divider = 0; state = IDLE. Takes effect immediately, including mid-scan or mid-handshake.
- States: IDLE, HOLD, SCAN. All outputs except in_ready are registered.
- in_ready = en & ~mode & ~rst. It is combinational from the current-cycle inputs.
- Accept: in_valid & in_ready at edge N. At edge N+1: out[sel] active and all other bits inactive; idx = sel; out_valid = 1; state = HOLD. Latency 1 cycle.
- Back-to-back accepts are allowed every cycle, and each one updates out on the following edge. No bubble is required.
- HOLD: out and idx are retained while no transaction is accepted. in_valid is ignored while in_ready = 0.
- en low in any state: at the next edge out goes inactive, out_valid = 0, wrap = 0, divider = 0, state = IDLE.
- Entering SCAN (en & mode = 1 from IDLE or HOLD): at the next edge idx = 0, out[0] active, out_valid = 1, divider = 0, state = SCAN.
- SCAN stepping:
  - divider counts 0..SCAN_DIV-1.
  - At the edge where divider = SCAN_DIV-1: divider returns to 0 and idx increments modulo OUT_W.
  - Each position stays active for exactly SCAN_DIV cycles.
  - SCAN_DIV = 1 steps every cycle.
- wrap = 1 for exactly one cycle, coincident with the first cycle idx = 0 after idx = OUT_W-1. It is not asserted on SCAN entry.
- SCAN to DECODE (mode falls, en high):
  - At the next edge out goes inactive, out_valid = 0, state = IDLE.
  - A handshake in that same cycle is accepted, because in_ready uses the current mode. When it is accepted, the decode result takes precedence and state = HOLD.
- Exactly one bit of out is active whenever out_valid = 1. No bit is active when out_valid = 0.
- sel is only sampled on accept. Any value 0..OUT_W-1 is legal, so there are no invalid codes.
- The divider width is sized for SCAN_DIV. idx wraps naturally at SEL_W bits.

Test Plan:
1. Defaults; rst pulse mid-cycle with out = 8'h20 -> out = 8'h00, out_valid = 0, idx = 0 immediately, before the next clk edge.
2. en = 1, mode = 0, sel = 5 with in_valid for one cycle -> next edge out = 8'h20, idx = 5, out_valid = 1. out is held for 10 idle cycles.
3. Back-to-back sel = 0, 7, 3 on consecutive cycles -> out = 8'h01, 8'h80, 8'h08 on consecutive edges. in_ready stays 1 throughout.
4. mode = 1, SCAN_DIV = 4 -> out = 8'h01 for 4 cycles, then 8'h02, ... 8'h80. After 32 cycles out = 8'h01 with wrap = 1 for one cycle. in_ready = 0 and in_valid is ignored.
5. Mid-scan at idx = 3: drop en -> next edge out = 0, out_valid = 0. Re-raise en -> scan restarts at idx = 0 with no wrap.
6. ACTIVE_LOW = 1, SEL_W = 4: accept sel = 9 -> out = 16'hFDFF. Reset value is 16'hFFFF.
